// File: rtl/imem_loader.sv
// Boot loader / fetch arbiter for the instruction RAM: LEN0 LEN1 DATA*4N CSUM byte stream, one-cycle registered writes.
// Optional inter-byte timeout when IMEM_LOADER_TIMEOUT_EN is defined; no rx backpressure, bytes accepted every cycle.
module imem_loader #(
  parameter int ADDR_W      = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  input  logic [31:0]       i_cpu_addr,
  output logic [31:0]       o_cpu_data,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic              o_mem_we,
  input  logic [31:0]       i_mem_rdata,
  output logic              o_cpu_hold,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  localparam int              DEPTH   = 2**ADDR_W;
  localparam logic [16:0]     DEPTH_W = 17'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_CSUM,
    S_ERR
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [7:0]        r_len_lo;
  logic [15:0]       r_len;
  logic [ADDR_W:0]   r_word_idx;
  logic [1:0]        r_byte_cnt;
  logic [23:0]       r_shift;
  logic [7:0]        r_acc;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [31:0]       r_wdata;
  logic              r_we;
  logic              r_done;
  logic              r_err;

  logic              w_loading;
  logic              w_restart;
  logic [15:0]       w_len;
  logic              w_len_bad;
  logic              w_last_byte;
  logic              w_last_word;
  logic              w_csum_ok;
  logic              w_in_range;
  logic [ADDR_W-1:0] w_load_addr;
  logic              w_timeout;
  logic              w_unused;

  assign w_loading   = (r_state == S_LEN0) || (r_state == S_LEN1) ||
                       (r_state == S_DATA) || (r_state == S_CSUM);
  assign w_restart   = i_start && ((r_state == S_IDLE) || (r_state == S_ERR));
  assign w_len       = {i_rx_data, r_len_lo};
  assign w_len_bad   = (w_len == 16'h0) || ({1'b0, w_len} > DEPTH_W);
  assign w_last_byte = (r_byte_cnt == 2'd3);
  assign w_last_word = (16'(r_word_idx) == (r_len - 16'd1));
  assign w_csum_ok   = (i_rx_data == r_acc);
  assign w_in_range  = (i_cpu_addr[30:ADDR_W+2] == '0);
  // During the write cycle the index has already advanced, so present the captured address instead.
  assign w_load_addr = r_we ? r_wr_addr : r_word_idx[ADDR_W-1:0];
  assign w_unused    = ^{i_cpu_addr[31], i_cpu_addr[1:0], 32'(TIMEOUT_CYC)};

`ifdef IMEM_LOADER_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYC - 1);
  logic [31:0] r_to_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_to_cnt <= 32'h0;
    end else if (!w_loading || i_rx_valid) begin
      r_to_cnt <= 32'h0;
    end else begin
      r_to_cnt <= r_to_cnt + 32'h1;
    end
  end

  assign w_timeout = w_loading && !i_rx_valid && (r_to_cnt == TO_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_busy      = 1'b0;
    o_cpu_hold  = 1'b0;
    o_cpu_data  = 32'h0;
    o_mem_addr  = i_cpu_addr[ADDR_W+1:2];
    case (r_state)
      S_IDLE: begin
        o_cpu_data = w_in_range ? i_mem_rdata : 32'h0;
        if (i_start) begin
          w_state_nxt = S_LEN0;
        end
      end
      S_LEN0: begin
        if (i_rx_valid) begin
          w_state_nxt = S_LEN1;
        end
      end
      S_LEN1: begin
        if (i_rx_valid) begin
          w_state_nxt = w_len_bad ? S_ERR : S_DATA;
        end
      end
      S_DATA: begin
        if (i_rx_valid && w_last_byte && w_last_word) begin
          w_state_nxt = S_CSUM;
        end
      end
      S_CSUM: begin
        if (i_rx_valid) begin
          w_state_nxt = w_csum_ok ? S_IDLE : S_ERR;
        end
      end
      S_ERR: begin
        if (i_start) begin
          w_state_nxt = S_LEN0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_loading) begin
      o_busy     = 1'b1;
      o_cpu_hold = 1'b1;
      o_mem_addr = w_load_addr;
      if (w_timeout) begin
        w_state_nxt = S_ERR;
      end
    end else if (r_state == S_ERR) begin
      o_cpu_hold = 1'b1;
      o_mem_addr = w_load_addr;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_len_lo   <= 8'h0;
      r_len      <= 16'h0;
      r_word_idx <= '0;
      r_byte_cnt <= 2'd0;
      r_shift    <= 24'h0;
      r_acc      <= 8'h0;
      r_wr_addr  <= '0;
      r_wdata    <= 32'h0;
      r_we       <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      // err mirrors residency in ERR, so it holds until a restart leaves that state.
      r_err  <= (w_state_nxt == S_ERR);
      if (w_restart) begin
        r_acc      <= 8'h0;
        r_word_idx <= '0;
        r_byte_cnt <= 2'd0;
        r_shift    <= 24'h0;
      end else if (i_rx_valid) begin
        case (r_state)
          S_LEN0: r_len_lo <= i_rx_data;
          S_LEN1: r_len    <= w_len;
          S_DATA: begin
            r_acc      <= r_acc ^ i_rx_data;
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (w_last_byte) begin
              r_we       <= 1'b1;
              r_wdata    <= {i_rx_data, r_shift};
              r_wr_addr  <= r_word_idx[ADDR_W-1:0];
              r_word_idx <= r_word_idx + 1'b1;
            end else begin
              r_shift <= {i_rx_data, r_shift[23:8]};
            end
          end
          S_CSUM: begin
            if (w_csum_ok) begin
              r_done <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign o_mem_we    = r_we;
  assign o_mem_wdata = r_wdata;
  assign o_done      = r_done;
  assign o_err       = r_err;

endmodule
